// File: rtl/pulse_timer_pkg.sv
// Shared definitions for the pulse_timer interval timer: state encodings and
// helpers so consumers can decode state_o symbolically.
package pulse_timer_pkg;

    // Code 2'b11 is unused; the timer falls back to ST_IDLE if it ever appears.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_OVF   = 2'b10
    } state_e;

    localparam logic [1:0] STATE_O_IDLE  = 2'b00;
    localparam logic [1:0] STATE_O_COUNT = 2'b01;
    localparam logic [1:0] STATE_O_OVF   = 2'b10;

    function automatic logic state_busy(input state_e st);
        return (st == ST_COUNT) || (st == ST_OVF);
    endfunction

endpackage

// File: rtl/pulse_timer_if.sv
// Control/status bundle of the pulse_timer; the timer side takes the slave
// modport, the trigger source / consumer takes the master modport.
interface pulse_timer_if #(
    parameter int unsigned CW = 32,
    parameter int unsigned PW = 16
) ();
    import pulse_timer_pkg::*;

    logic          start;
    logic          abort;
    logic          periodic;
    logic [CW-1:0] n;
    state_e        state_o;
    logic          busy;
    logic          done;
    logic [CW-1:0] count_o;
    logic [PW-1:0] periods;

    modport master (
        output start,
        output abort,
        output periodic,
        output n,
        input  state_o,
        input  busy,
        input  done,
        input  count_o,
        input  periods
    );

    modport slave (
        input  start,
        input  abort,
        input  periodic,
        input  n,
        output state_o,
        output busy,
        output done,
        output count_o,
        output periods
    );

endinterface

// File: rtl/pulse_timer.sv
// Start-triggered interval timer: counts n+1 cycles, flags one OVF/done cycle,
// optionally auto-restarts, and keeps a saturating completed-period count.
module pulse_timer
    import pulse_timer_pkg::*;
#(
    parameter int unsigned CW     = 32,
    parameter int unsigned PW     = 16,
    parameter bit          RETRIG = 1'b0
) (
    input logic          clk,
    input logic          rstn,
    pulse_timer_if.slave tmr
);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_q, n_d;
    logic [PW-1:0] per_q, per_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            n_q     <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            n_q     <= n_d;
            per_q   <= per_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        n_d     = n_q;
        per_d   = per_q;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (tmr.start && !tmr.abort) begin
                    state_d = ST_COUNT;
                    n_d     = tmr.n;
                    per_d   = '0;
                end
            end
            ST_COUNT: begin
                if (tmr.abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (RETRIG && tmr.start) begin
                    count_d = '0;
                    n_d     = tmr.n;
                end else if (count_q == n_q) begin
                    state_d = ST_OVF;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_OVF: begin
                count_d = '0;
                // Abort takes precedence over the period credit as well.
                if (tmr.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    per_d = (&per_q) ? per_q : per_q + 1'b1;
                    if (tmr.periodic) begin
                        state_d = ST_COUNT;
                    end else if (tmr.start) begin
                        state_d = ST_COUNT;
                        n_d     = tmr.n;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign tmr.state_o = state_q;
    assign tmr.busy    = state_busy(state_q);
    assign tmr.done    = (state_q == ST_OVF);
    assign tmr.count_o = (state_q == ST_COUNT) ? count_q : '0;
    assign tmr.periods = per_q;

endmodule

// File: tb/tb_pulse_timer.sv
// Bench for pulse_timer: three instances (wide, retriggerable, narrow) share one
// stimulus stream and are checked every cycle against an elapsed-time model.
module tb_pulse_timer;
    import pulse_timer_pkg::*;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        abort;
    logic        periodic;
    logic [31:0] nv;

    int n_cmp = 0;
    int n_err = 0;

    pulse_timer_if #(.CW(32), .PW(16)) if_a ();
    pulse_timer_if #(.CW(8),  .PW(16)) if_b ();
    pulse_timer_if #(.CW(4),  .PW(2))  if_c ();

    assign if_a.start = start;    assign if_a.abort = abort;
    assign if_b.start = start;    assign if_b.abort = abort;
    assign if_c.start = start;    assign if_c.abort = abort;
    assign if_a.periodic = periodic;
    assign if_b.periodic = periodic;
    assign if_c.periodic = periodic;
    assign if_a.n = nv;
    assign if_b.n = nv[7:0];
    assign if_c.n = nv[3:0];

    pulse_timer #(.CW(32), .PW(16), .RETRIG(1'b0)) u_a (.clk(clk), .rstn(rstn), .tmr(if_a));
    pulse_timer #(.CW(8),  .PW(16), .RETRIG(1'b1)) u_b (.clk(clk), .rstn(rstn), .tmr(if_b));
    pulse_timer #(.CW(4),  .PW(2),  .RETRIG(1'b0)) u_c (.clk(clk), .rstn(rstn), .tmr(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: el = cycles since the interval began; el==nl+1 is the overflow cycle.
    typedef struct {
        bit     active;
        longint el;
        longint nl;
        longint per;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t step(input mdl_t m, input bit st, input bit ab, input bit pe,
                                  input longint nn, input bit rt, input longint pmax);
        mdl_t r = m;
        if (!m.active) begin
            if (st && !ab) begin
                r.active = 1; r.el = 0; r.nl = nn; r.per = 0;
            end
        end else if (ab) begin
            r.active = 0;
        end else if (m.el == m.nl + 1) begin
            r.per = (m.per == pmax) ? m.per : m.per + 1;
            if (pe) r.el = 0;
            else if (st) begin r.el = 0; r.nl = nn; end
            else r.active = 0;
        end else if (rt && st) begin
            r.el = 0; r.nl = nn;
        end else begin
            r.el = m.el + 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input mdl_t m, input logic [63:0] so,
                             input logic [63:0] bz, input logic [63:0] dn,
                             input logic [63:0] cnt, input logic [63:0] per);
        logic [63:0] st;
        if (!m.active)              st = 64'(STATE_O_IDLE);
        else if (m.el == m.nl + 1)  st = 64'(STATE_O_OVF);
        else                        st = 64'(STATE_O_COUNT);
        chk({tag, ".state"}, so, st);
        chk({tag, ".busy"}, bz, 64'(m.active));
        chk({tag, ".done"}, dn, 64'(st == 64'(STATE_O_OVF)));
        chk({tag, ".count"}, cnt, (st == 64'(STATE_O_COUNT)) ? 64'(m.el) : 64'd0);
        chk({tag, ".periods"}, per, 64'(m.per));
    endtask

    task automatic check_all();
        check_dut("a", ma, 64'(if_a.state_o), 64'(if_a.busy), 64'(if_a.done),
                  64'(if_a.count_o), 64'(if_a.periods));
        check_dut("b", mb, 64'(if_b.state_o), 64'(if_b.busy), 64'(if_b.done),
                  64'(if_b.count_o), 64'(if_b.periods));
        check_dut("c", mc, 64'(if_c.state_o), 64'(if_c.busy), 64'(if_c.done),
                  64'(if_c.count_o), 64'(if_c.periods));
    endtask

    task automatic reset_models();
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        mc = '{0, 0, 0, 0};
    endtask

    task automatic tick();
        @(posedge clk);
        ma = step(ma, start, abort, periodic, longint'(nv), 1'b0, 65535);
        mb = step(mb, start, abort, periodic, longint'(nv[7:0]), 1'b1, 65535);
        mc = step(mc, start, abort, periodic, longint'(nv[3:0]), 1'b0, 3);
        #1;
        check_all();
    endtask

    initial begin
        int a_off;
        int b_off;
        int c_off;
        int guard;
        longint cmax;

        rstn = 1'b0; start = 0; abort = 0; periodic = 0; nv = '0;
        reset_models();
        #3;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // One-shot, n=5: done on the 6th edge after the start edge.
        nv = 5; start = 1; tick(); start = 0;
        a_off = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (if_a.done && a_off < 0) a_off = t;
        end
        chk("oneshot_done_offset", 64'(a_off), 64'd6);
        chk("oneshot_periods", 64'(if_a.periods), 64'd1);

        // Periodic, n=3: four completed periods in 25 edges; narrow copy saturates.
        nv = 3; periodic = 1; start = 1; tick(); start = 0;
        cmax = 0;
        for (int t = 1; t < 25; t++) begin
            tick();
            if (longint'(if_a.count_o) > cmax) cmax = longint'(if_a.count_o);
        end
        chk("periodic_count_max", 64'(cmax), 64'd3);
        chk("periodic_periods_a", 64'(if_a.periods), 64'd4);
        chk("periodic_periods_c_sat", 64'(if_c.periods), 64'd3);
        periodic = 0; abort = 1; tick(); abort = 0;
        chk("abort_periodic_idle", 64'(if_a.state_o), 64'(STATE_O_IDLE));

        // Abort at count 4 with n=10, then abort+start together from idle.
        nv = 10; start = 1; tick(); start = 0;
        guard = 0;
        while (if_a.count_o != 4 && guard < 50) begin tick(); guard++; end
        chk("abort_reach_count4", 64'(guard < 50), 64'd1);
        abort = 1; tick(); abort = 0;
        chk("abort_idle", 64'(if_a.state_o), 64'(STATE_O_IDLE));
        chk("abort_no_done", 64'(if_a.done), 64'd0);
        abort = 1; start = 1; tick(); abort = 0; start = 0;
        chk("abort_start_stays_idle", 64'(if_a.busy), 64'd0);

        // Retrigger at count 6 with new n=2: b restarts, a keeps the original interval.
        nv = 8; start = 1; tick(); start = 0;
        guard = 0;
        while (if_b.count_o != 6 && guard < 50) begin tick(); guard++; end
        chk("retrig_reach_count6", 64'(guard < 50), 64'd1);
        nv = 2; start = 1; tick(); start = 0;
        a_off = -1; b_off = -1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (if_a.done && a_off < 0) a_off = t;
            if (if_b.done && b_off < 0) b_off = t;
        end
        chk("retrig_b_done_offset", 64'(b_off), 64'd3);
        chk("noretrig_a_done_offset", 64'(a_off), 64'd2);

        // Narrow instance with n=15: full-width compare, overflow after 16 count cycles.
        nv = 15; start = 1; tick(); start = 0;
        c_off = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (if_c.done && c_off < 0) c_off = t;
        end
        chk("cw4_done_offset", 64'(c_off), 64'd16);

        // Asynchronous reset in the middle of a long count.
        nv = 100; start = 1; tick(); start = 0;
        for (int t = 0; t < 30; t++) tick();
        @(negedge clk);
        rstn = 1'b0;
        reset_models();
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        for (int t = 0; t < 3; t++) tick();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            start = ($urandom_range(7) == 0);
            abort = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) periodic = ~periodic;
            if ($urandom_range(3) == 0) nv = $urandom_range(12);
            if ($urandom_range(63) == 0) nv = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
